spi_mem_responder: RTL and testbench
====================================

// Module: spi_mem_responder
// PURPOSE
//  Synthesizable SPI mode-0 responder (single-lane, MSB first) with a byte-addressed memory.
//  Sits on the far end of the HEEPerator SPI host pins (spi_sck/spi_cs_0/spi_sd_0..1) and
//  answers READ/WRITE/WREN/WRDI/RDSR/RDID. Replaces the behavioural flash model where
//  Verilator is used. A backdoor port lets the bench preload and check memory contents.
// PARAMETERS
//  MemBytes    256        memory size in bytes (power of two); address wraps modulo MemBytes
//  SyncStages  2          synchronizer depth for sck/csb/mosi (>=2)
//  JedecId     24'hEF4018 3-byte ID returned by RDID, MSB byte first
// PORTS
//  clk_i        in   1    system clock; must be >= 8x SCK frequency
//  rst_ni       in   1    asynchronous active-low reset
//  spi_sck_i    in   1    SPI clock from host
//  spi_csb_i    in   1    chip select, active low
//  spi_mosi_i   in   1    host-to-device data (sd_0)
//  spi_miso_o   out  1    device-to-host data (sd_1)
//  spi_miso_oe_o out 1    output enable for spi_miso_o (tri-state driven by wrapper)
//  bd_we_i      in   1    backdoor write enable
//  bd_addr_i    in   $clog2(MemBytes) backdoor address
//  bd_wdata_i   in   8    backdoor write data
//  bd_rdata_o   out  8    backdoor read data, 1-cycle latency
//  busy_o       out  1    synchronized csb asserted
//  cmd_cnt_o    out  16   completed-command counter, wraps at 16'hFFFF
// BEHAVIOUR
//  - Reset: miso_o=0, miso_oe_o=0, busy_o=0, cmd_cnt_o=0, bd_rdata_o=0, WEL=0, FSM=IDLE.
//    Memory array is not reset.
//  - sck/csb/mosi pass through SyncStages flops; edges are detected on synchronized sck.
//    Sample mosi on the rising edge; update miso on the falling edge (mode 0).
//  - FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, RDSR, RDID, IGNORE.
//    IDLE->CMD on csb falling. CMD shifts 8 bits, then decodes:
//    03h/02h->ADDR; 05h->RDSR; 9Fh->RDID; 06h sets WEL and goes to IGNORE;
//    04h clears WEL and goes to IGNORE; any other opcode->IGNORE.
//  - ADDR shifts 24 bits; addr = low $clog2(MemBytes) bits. Then 03h->RD_DATA, 02h->WR_DATA.
//  - RD_DATA: mem[addr] loads the shift register after the last address rising edge.
//    bit7 is driven on the next falling edge. After each 8th bit, addr increments (wraps
//    MemBytes-1 -> 0) and the next byte loads seamlessly. oe=1 only in RD_DATA/RDSR/RDID.
//  - WR_DATA: on each 8th rising edge, mem[addr] <= byte and addr increments (wrap),
//    but only if WEL=1; otherwise data is dropped. Partial bytes are discarded.
//  - RDSR: repeatedly returns {6'b0, WEL, 1'b0}. RDID: returns JedecId bytes 2,1,0, then
//    repeats byte 0.
//  - csb rising (sync) in any state: FSM->IDLE, oe=0, and bit/byte counters cleared.
//    cmd_cnt_o increments if a full opcode was received. WEL clears if the opcode was 02h
//    and >=1 byte was committed. csb rising and sck edge in the same cycle: csb wins.
//  - Backdoor: a write is committed on clk_i. On a same-cycle, same-address collision with
//    an SPI write, the SPI write wins. bd_rdata_o <= mem[bd_addr_i] every cycle.
//  - Reset asserted mid-transfer: immediate return to reset values; memory retained.
// STRUCTURE
//  - spi_mem_pkg: opcode localparams (OP_READ=8'h03, OP_WRITE=8'h02, OP_WREN=8'h06,
//    OP_WRDI=8'h04, OP_RDSR=8'h05, OP_RDID=8'h9F), state enum spi_mem_state_e.
//  - Sub-module spi_mem_sync: synchronizer plus rise/fall detect for sck, csb rise/fall,
//    and mosi.
//  - Top: FSM, 8-bit shift regs, 5-bit bit counter, address counter, memory array.
// TESTING
//  1 Reset with no activity -> miso_oe_o=0, cmd_cnt_o=0, busy_o=0.
//  2 Backdoor mem[10h..13h]=A1,B2,C3,D4; SPI 03h addr 000010h, 4 bytes -> A1 B2 C3 D4;
//    cmd_cnt_o=1.
//  3 02h addr 0000FEh data 11,22,33 without WREN -> backdoor reads unchanged.
//    06h, then same write -> mem[FE]=11, mem[FF]=22, mem[00]=33 (wrap). RDSR then -> 00h.
//  4 06h; RDSR -> 02h; 04h; RDSR -> 00h; 9Fh -> EF 40 18 18.
//  5 csb deasserted after 13 bits of an address phase -> next 03h addr 000010h works
//    normally; unknown opcode ABh -> oe stays 0 and cmd_cnt_o increments.
//  6 rst_ni pulsed mid RD_DATA byte -> outputs at reset values; memory contents intact.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared opcodes, FSM state encoding and state helpers for the SPI memory responder.
package spi_mem_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_RDID  = 8'h9F;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_RDSR    = 3'd5,
    ST_RDID    = 3'd6,
    ST_IGNORE  = 3'd7
  } spi_mem_state_e;

  // States in which the responder drives miso.
  function automatic logic is_out_state(spi_mem_state_e s);
    return (s == ST_RD_DATA) || (s == ST_RDSR) || (s == ST_RDID);
  endfunction

endpackage

// File: rtl/spi_mem_sync.sv
// Synchronizes the asynchronous SPI pins into clk and flags sck/csb edges.
// Ports: clk, rst_n; sck/csb/mosi raw pins; sck_rise_c/sck_fall_c/csb_rise_c/csb_fall_c
// single-cycle edge pulses; csb_s and mosi_s synchronized levels.
module spi_mem_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic csb,
  input  logic mosi,
  output logic sck_rise_c,
  output logic sck_fall_c,
  output logic csb_rise_c,
  output logic csb_fall_c,
  output logic csb_s,
  output logic mosi_s
);

  logic [Stages-1:0] sck_q;
  logic [Stages-1:0] csb_q;
  logic [Stages-1:0] mosi_q;
  logic              sck_prev;
  logic              csb_prev;
  logic              sck_s;

  // Synchronizer chains; csb resets deasserted so reset release creates no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q    <= '0;
      csb_q    <= '1;
      mosi_q   <= '0;
      sck_prev <= 1'b0;
      csb_prev <= 1'b1;
    end else begin
      sck_q    <= {sck_q[Stages-2:0], sck};
      csb_q    <= {csb_q[Stages-2:0], csb};
      mosi_q   <= {mosi_q[Stages-2:0], mosi};
      sck_prev <= sck_s;
      csb_prev <= csb_s;
    end
  end

  assign sck_s      = sck_q[Stages-1];
  assign csb_s      = csb_q[Stages-1];
  assign mosi_s     = mosi_q[Stages-1];
  assign sck_rise_c = sck_s & ~sck_prev;
  assign sck_fall_c = ~sck_s & sck_prev;
  assign csb_rise_c = csb_s & ~csb_prev;
  assign csb_fall_c = ~csb_s & csb_prev;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder (single lane, MSB first) backed by a byte-addressed memory.
// Ports: clk_i/rst_ni; spi_sck_i/spi_csb_i/spi_mosi_i host pins; spi_miso_o with
// spi_miso_oe_o enable; bd_we_i/bd_addr_i/bd_wdata_i/bd_rdata_o backdoor access;
// busy_o (csb asserted); cmd_cnt_o completed-command count.
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int unsigned MemBytes   = 256,
  parameter int unsigned SyncStages = 2,
  parameter logic [23:0] JedecId    = 24'hEF4018
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        spi_sck_i,
  input  logic                        spi_csb_i,
  input  logic                        spi_mosi_i,
  output logic                        spi_miso_o,
  output logic                        spi_miso_oe_o,
  input  logic                        bd_we_i,
  input  logic [$clog2(MemBytes)-1:0] bd_addr_i,
  input  logic [7:0]                  bd_wdata_i,
  output logic [7:0]                  bd_rdata_o,
  output logic                        busy_o,
  output logic [15:0]                 cmd_cnt_o
);

  localparam int unsigned AW = $clog2(MemBytes);

  logic sck_rise_c, sck_fall_c, csb_rise_c, csb_fall_c, csb_s, mosi_s;

  spi_mem_sync #(.Stages(SyncStages)) u_sync (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .sck        (spi_sck_i),
    .csb        (spi_csb_i),
    .mosi       (spi_mosi_i),
    .sck_rise_c (sck_rise_c),
    .sck_fall_c (sck_fall_c),
    .csb_rise_c (csb_rise_c),
    .csb_fall_c (csb_fall_c),
    .csb_s      (csb_s),
    .mosi_s     (mosi_s)
  );

  logic [7:0]     mem [MemBytes];
  spi_mem_state_e state_q, state_d;
  logic [7:0]     shreg_in, shreg_out, opcode;
  logic [4:0]     bit_cnt;
  logic [AW-1:0]  addr;
  logic [1:0]     id_idx;
  logic           wel, op_done, wr_done;

  logic [7:0]    in_byte_c, next_byte_c, status_c;
  logic [AW-1:0] addr_next_c, addr_inc_c;
  logic          spi_we_c;

  assign in_byte_c   = {shreg_in[6:0], mosi_s};
  assign addr_next_c = {addr[AW-2:0], mosi_s};
  assign addr_inc_c  = addr + AW'(1);
  assign status_c    = {6'b0, wel, 1'b0};
  assign spi_we_c    = sck_rise_c && !csb_rise_c && !csb_fall_c && (state_q == ST_WR_DATA)
                       && (bit_cnt == 5'd7) && wel;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; csb edges take priority over any sck edge.
  always_comb begin
    state_d = state_q;
    if (csb_rise_c) begin
      state_d = ST_IDLE;
    end else if (csb_fall_c) begin
      state_d = ST_CMD;
    end else if (sck_rise_c) begin
      case (state_q)
        ST_CMD: begin
          if (bit_cnt == 5'd7) begin
            case (in_byte_c)
              OP_READ, OP_WRITE: state_d = ST_ADDR;
              OP_RDSR:           state_d = ST_RDSR;
              OP_RDID:           state_d = ST_RDID;
              default:           state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (bit_cnt == 5'd23) state_d = (opcode == OP_READ) ? ST_RD_DATA : ST_WR_DATA;
        end
        default: ;
      endcase
    end
  end

  // Byte to present after the current output byte has fully shifted out.
  always_comb begin
    next_byte_c = '0;
    case (state_q)
      ST_RD_DATA: next_byte_c = mem[addr_inc_c];
      ST_RDSR:    next_byte_c = status_c;
      ST_RDID:    next_byte_c = (id_idx == 2'd1) ? JedecId[15:8] : JedecId[7:0];
      default:    ;
    endcase
  end

  // Datapath: shifting, counters, WEL, command counting and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_in      <= '0;
      shreg_out     <= '0;
      opcode        <= '0;
      bit_cnt       <= '0;
      addr          <= '0;
      id_idx        <= '0;
      wel           <= 1'b0;
      op_done       <= 1'b0;
      wr_done       <= 1'b0;
      spi_miso_o    <= 1'b0;
      spi_miso_oe_o <= 1'b0;
      busy_o        <= 1'b0;
      cmd_cnt_o     <= '0;
      bd_rdata_o    <= '0;
    end else begin
      busy_o        <= ~csb_s;
      spi_miso_oe_o <= is_out_state(state_d);
      bd_rdata_o    <= mem[bd_addr_i];
      if (csb_rise_c) begin
        bit_cnt <= '0;
        op_done <= 1'b0;
        wr_done <= 1'b0;
        if (op_done) cmd_cnt_o <= cmd_cnt_o + 16'd1;
        if ((opcode == OP_WRITE) && wr_done) wel <= 1'b0;
      end else if (csb_fall_c) begin
        bit_cnt  <= '0;
        op_done  <= 1'b0;
        wr_done  <= 1'b0;
        shreg_in <= '0;
      end else if (sck_rise_c) begin
        shreg_in <= in_byte_c;
        case (state_q)
          ST_CMD: begin
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              opcode  <= in_byte_c;
              op_done <= 1'b1;
              if (in_byte_c == OP_WREN) wel <= 1'b1;
              if (in_byte_c == OP_WRDI) wel <= 1'b0;
              if (in_byte_c == OP_RDSR) shreg_out <= status_c;
              if (in_byte_c == OP_RDID) begin
                shreg_out <= JedecId[23:16];
                id_idx    <= 2'd1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_ADDR: begin
            addr <= addr_next_c;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (opcode == OP_READ) shreg_out <= mem[addr_next_c];
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ST_WR_DATA: begin
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              if (wel) begin
                addr    <= addr_inc_c;
                wr_done <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: ;
        endcase
      end else if (sck_fall_c && is_out_state(state_q)) begin
        spi_miso_o <= shreg_out[7];
        if (bit_cnt == 5'd7) begin
          bit_cnt   <= '0;
          shreg_out <= next_byte_c;
          if (state_q == ST_RD_DATA) addr <= addr_inc_c;
          if ((state_q == ST_RDID) && (id_idx != 2'd2)) id_idx <= id_idx + 2'd1;
        end else begin
          bit_cnt   <= bit_cnt + 5'd1;
          shreg_out <= {shreg_out[6:0], 1'b0};
        end
      end
    end
  end

  // Memory array (not reset); an SPI write overrides a same-address backdoor write.
  always_ff @(posedge clk_i) begin
    if (bd_we_i)  mem[bd_addr_i] <= bd_wdata_i;
    if (spi_we_c) mem[addr]      <= in_byte_c;
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: SPI host tasks, backdoor preload/readback.
module tb_spi_mem_responder;

  logic       clk;
  logic       rst_n;
  logic       sck, csb, mosi;
  logic       miso, miso_oe;
  logic       bd_we;
  logic [7:0] bd_addr, bd_wdata, bd_rdata;
  logic       busy;
  logic [15:0] cmd_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx;
  logic [7:0] dummy;

  spi_mem_responder #(
    .MemBytes   (256),
    .SyncStages (2),
    .JedecId    (24'hEF4018)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .spi_sck_i     (sck),
    .spi_csb_i     (csb),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (miso_oe),
    .bd_we_i       (bd_we),
    .bd_addr_i     (bd_addr),
    .bd_wdata_i    (bd_wdata),
    .bd_rdata_o    (bd_rdata),
    .busy_o        (busy),
    .cmd_cnt_o     (cmd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift nbits of tx out MSB first; miso is sampled at each rising sck edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
    rxb = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[3'(7 - i)];
      wait_clk(8);
      sck = 1'b1;
      rxb = {rxb[6:0], miso};
      wait_clk(8);
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    csb = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_high();
    wait_clk(8);
    csb = 1'b1;
    wait_clk(16);
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    bd_addr  = a;
    bd_wdata = d;
    bd_we    = 1'b1;
    wait_clk(1);
    bd_we    = 1'b0;
  endtask

  task automatic bd_read(input logic [7:0] a, output logic [7:0] d);
    bd_addr = a;
    wait_clk(2);
    d = bd_rdata;
  endtask

  task automatic send_addr(input logic [7:0] op, input logic [7:0] a);
    xfer(op, 8, dummy);
    xfer(8'h00, 8, dummy);
    xfer(8'h00, 8, dummy);
    xfer(a, 8, dummy);
  endtask

  task automatic one_byte_cmd(input logic [7:0] op);
    cs_low();
    xfer(op, 8, dummy);
    cs_high();
  endtask

  initial begin
    sck = 1'b0; csb = 1'b1; mosi = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    rst_n = 1'b0;

    // 1: reset values
    wait_clk(4);
    chk("rst_bd_rdata", 32'(bd_rdata), 32'h00);
    chk("rst_miso", 32'(miso), 32'h0);
    rst_n = 1'b1;
    wait_clk(6);
    chk("rst_oe", 32'(miso_oe), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cmd_cnt", 32'(cmd_cnt), 32'h0);

    // 2: backdoor preload then SPI read of 4 bytes
    bd_write(8'h10, 8'hA1);
    bd_write(8'h11, 8'hB2);
    bd_write(8'h12, 8'hC3);
    bd_write(8'h13, 8'hD4);
    cs_low();
    chk("busy_active", 32'(busy), 32'h1);
    send_addr(8'h03, 8'h10);
    chk("read_oe", 32'(miso_oe), 32'h1);
    xfer(8'h00, 8, rx); chk("read_b0", 32'(rx), 32'hA1);
    xfer(8'h00, 8, rx); chk("read_b1", 32'(rx), 32'hB2);
    xfer(8'h00, 8, rx); chk("read_b2", 32'(rx), 32'hC3);
    xfer(8'h00, 8, rx); chk("read_b3", 32'(rx), 32'hD4);
    cs_high();
    chk("read_oe_off", 32'(miso_oe), 32'h0);
    chk("cmd_cnt_1", 32'(cmd_cnt), 32'd1);

    // 3: write without WREN is dropped; with WREN it lands and wraps
    bd_write(8'hFE, 8'h5A);
    bd_write(8'hFF, 8'h6B);
    bd_write(8'h00, 8'h7C);
    cs_low();
    send_addr(8'h02, 8'hFE);
    xfer(8'h11, 8, dummy); xfer(8'h22, 8, dummy); xfer(8'h33, 8, dummy);
    cs_high();
    bd_read(8'hFE, rx); chk("nowel_fe", 32'(rx), 32'h5A);
    bd_read(8'hFF, rx); chk("nowel_ff", 32'(rx), 32'h6B);
    bd_read(8'h00, rx); chk("nowel_00", 32'(rx), 32'h7C);
    one_byte_cmd(8'h06);
    cs_low();
    send_addr(8'h02, 8'hFE);
    xfer(8'h11, 8, dummy); xfer(8'h22, 8, dummy); xfer(8'h33, 8, dummy);
    cs_high();
    bd_read(8'hFE, rx); chk("wel_fe", 32'(rx), 32'h11);
    bd_read(8'hFF, rx); chk("wel_ff", 32'(rx), 32'h22);
    bd_read(8'h00, rx); chk("wel_00_wrap", 32'(rx), 32'h33);
    cs_low(); xfer(8'h05, 8, dummy); xfer(8'h00, 8, rx); cs_high();
    chk("rdsr_after_write", 32'(rx), 32'h00);
    chk("cmd_cnt_5", 32'(cmd_cnt), 32'd5);

    // 4: WREN/WRDI visible via RDSR; RDID sequence
    one_byte_cmd(8'h06);
    cs_low(); xfer(8'h05, 8, dummy);
    xfer(8'h00, 8, rx); chk("rdsr_wel_b0", 32'(rx), 32'h02);
    xfer(8'h00, 8, rx); chk("rdsr_wel_b1", 32'(rx), 32'h02);
    cs_high();
    one_byte_cmd(8'h04);
    cs_low(); xfer(8'h05, 8, dummy); xfer(8'h00, 8, rx); cs_high();
    chk("rdsr_wrdi", 32'(rx), 32'h00);
    cs_low(); xfer(8'h9F, 8, dummy);
    xfer(8'h00, 8, rx); chk("rdid_b0", 32'(rx), 32'hEF);
    xfer(8'h00, 8, rx); chk("rdid_b1", 32'(rx), 32'h40);
    xfer(8'h00, 8, rx); chk("rdid_b2", 32'(rx), 32'h18);
    xfer(8'h00, 8, rx); chk("rdid_b3", 32'(rx), 32'h18);
    cs_high();
    chk("cmd_cnt_10", 32'(cmd_cnt), 32'd10);

    // 5: aborted address phase, then normal read; unknown opcode
    cs_low(); xfer(8'h03, 8, dummy); xfer(8'h00, 8, dummy); xfer(8'h00, 5, dummy); cs_high();
    chk("cmd_cnt_abort", 32'(cmd_cnt), 32'd11);
    cs_low();
    send_addr(8'h03, 8'h10);
    xfer(8'h00, 8, rx); chk("reread_b0", 32'(rx), 32'hA1);
    xfer(8'h00, 8, rx); chk("reread_b1", 32'(rx), 32'hB2);
    cs_high();
    cs_low(); xfer(8'hAB, 8, dummy); xfer(8'h00, 8, dummy);
    chk("unknown_oe", 32'(miso_oe), 32'h0);
    cs_high();
    chk("cmd_cnt_13", 32'(cmd_cnt), 32'd13);

    // 6: reset in the middle of a read byte
    cs_low();
    send_addr(8'h03, 8'h10);
    xfer(8'h00, 4, dummy);
    rst_n = 1'b0;
    wait_clk(2);
    chk("midrst_miso", 32'(miso), 32'h0);
    chk("midrst_oe", 32'(miso_oe), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_cmd_cnt", 32'(cmd_cnt), 32'h0);
    chk("midrst_bd_rdata", 32'(bd_rdata), 32'h00);
    csb = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(10);
    chk("postrst_busy", 32'(busy), 32'h0);
    bd_read(8'h10, rx); chk("keep_10", 32'(rx), 32'hA1);
    bd_read(8'h13, rx); chk("keep_13", 32'(rx), 32'hD4);
    bd_read(8'hFF, rx); chk("keep_ff", 32'(rx), 32'h22);
    cs_low();
    send_addr(8'h03, 8'hFE);
    xfer(8'h00, 8, rx); chk("postrst_fe", 32'(rx), 32'h11);
    xfer(8'h00, 8, rx); chk("postrst_ff", 32'(rx), 32'h22);
    xfer(8'h00, 8, rx); chk("postrst_00", 32'(rx), 32'h33);
    cs_high();
    chk("postrst_cmd_cnt", 32'(cmd_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
